// File: rtl/enc_pkg.sv
// Shared types and defaults for the bitmask index encoder.
package enc_pkg;
    localparam int DEFAULT_N = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;
endpackage

// File: rtl/bitmask_index_encoder_msb_finder.sv
// Combinational: index of the highest set bit of vec, plus a flag for exactly-one-bit-set.
module msb_finder
    import enc_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         single_bit
);

    always_comb begin
        idx = '0;
        // Ascending scan: the last hit wins, leaving the most-significant set bit.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
        single_bit = (vec != '0) && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/bitmask_index_encoder.sv
// Turns an accepted multi-hot vector into one index per output handshake, MSB first; ENC_ZERO_FLAG_EN adds zero_err.
// Latency: first index valid the cycle after input accept; one IDLE bubble between vectors.
// Backpressure: out_ready low holds out/out_last/out_valid and pending bits; in_ready low while emitting.
module bitmask_index_encoder
    import enc_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_last
`ifdef ENC_ZERO_FLAG_EN
    ,
    output logic         zero_err
`endif
);

    enc_state_t   state, state_nxt;
    logic [N-1:0] pend, pend_nxt;
    logic [W-1:0] msb_idx;
    logic         single_bit;

    msb_finder #(.N(N)) u_msb_finder (
        .vec        (pend),
        .idx        (msb_idx),
        .single_bit (single_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                // in is only looked at under in_valid, so X on an idle bus stays out of pend.
                if (in_valid && (in != '0)) begin
                    pend_nxt  = in;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pend_nxt = pend & ~(N'(1) << msb_idx);
                    if (single_bit) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pend is zero outside EMIT, so out reads 0 whenever idle.
    assign out      = msb_idx;
    assign out_last = out_valid & single_bit;

`ifdef ENC_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_err <= 1'b0;
        end else begin
            zero_err <= (state == IDLE) && in_valid && (in == '0);
        end
    end
`endif

endmodule

// File: tb/tb_bitmask_index_encoder.sv
module tb_bitmask_index_encoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out;
    logic       out_last;
`ifdef ENC_ZERO_FLAG_EN
    logic       zero_err;
`endif

    int checks   = 0;
    int failures = 0;

    bitmask_index_encoder #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_last  (out_last)
`ifdef ENC_ZERO_FLAG_EN
        ,
        .zero_err  (zero_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: expected index stream is the set bits of v listed from high to low.
    task automatic send_vec(input logic [3:0] v, input int hold, input bit bp, output int n_out, output int cycles);
        logic [1:0] exp_q[$];
        logic [3:0] dec;
        logic [1:0] seen;
        bit         rdy;
        n_out  = 0;
        cycles = 0;
        dec    = 4'b0000;
        for (int b = 3; b >= 0; b--) begin
            if (v[b]) exp_q.push_back(2'(b));
        end
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in       = v;
        @(negedge clk);
        in_valid = 1'b0;
        in       = 4'bxxxx;
        if (exp_q.size() == 0) begin
            check("zero_no_valid", 32'(out_valid), 32'd0);
            check("zero_in_ready", 32'(in_ready), 32'd1);
`ifdef ENC_ZERO_FLAG_EN
            check("zero_err_pulse", 32'(zero_err), 32'd1);
            @(negedge clk);
            check("zero_err_clear", 32'(zero_err), 32'd0);
`endif
            return;
        end
        while (exp_q.size() > 0 && cycles < 200) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("in_ready_emit", 32'(in_ready), 32'd0);
            check("out_idx", 32'(out), 32'(exp_q[0]));
            check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
            seen = out;
            rdy  = (cycles < hold) ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            out_ready = rdy;
            @(negedge clk);
            if (rdy) begin
                dec = dec | (4'b0001 << seen);
                void'(exp_q.pop_front());
                n_out++;
            end
            cycles++;
        end
        out_ready = 1'b1;
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        check("decode_roundtrip", 32'(dec), 32'(v));
    endtask

    typedef struct {
        logic [3:0] vec;
        int         hold;
        bit         bp;
        int         exp_cnt;
        logic [1:0] exp_first;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n, cyc;
        logic [3:0] rv;
        bit rbp;

        tbl.push_back('{4'b1011, 0, 1'b0, 3, 2'd3});
        tbl.push_back('{4'b0001, 0, 1'b0, 1, 2'd0});
        tbl.push_back('{4'b0010, 0, 1'b0, 1, 2'd1});
        tbl.push_back('{4'b0100, 0, 1'b0, 1, 2'd2});
        tbl.push_back('{4'b1000, 0, 1'b0, 1, 2'd3});
        tbl.push_back('{4'b1100, 5, 1'b0, 2, 2'd3});
        tbl.push_back('{4'b0000, 0, 1'b0, 0, 2'd0});
        tbl.push_back('{4'b1111, 2, 1'b1, 4, 2'd3});
        tbl.push_back('{4'b0110, 0, 1'b0, 2, 2'd2});

        in_valid  = 1'b0;
        in        = 4'bxxxx;
        out_ready = 1'b1;
        rst       = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
`ifdef ENC_ZERO_FLAG_EN
        check("rst_zero_err", 32'(zero_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            check("tbl_first_peek_idle", 32'(out_valid), 32'd0);
            send_vec(tbl[i].vec, tbl[i].hold, tbl[i].bp, n, cyc);
            check("tbl_count", 32'(n), 32'(tbl[i].exp_cnt));
            if (tbl[i].exp_cnt > 0 && tbl[i].hold == 0 && !tbl[i].bp)
                check("tbl_throughput", 32'(cyc), 32'(tbl[i].exp_cnt));
        end

        // Reset after the first transfer of 1111 must discard the remaining bits.
        @(negedge clk);
        in_valid  = 1'b1;
        in        = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in       = 4'bxxxx;
        check("mid_first", 32'(out), 32'd3);
        @(negedge clk);
        check("mid_second", 32'(out), 32'd2);
        check("mid_second_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(out_valid), 32'd0);
        send_vec(4'b0100, 0, 1'b0, n, cyc);
        check("post_rst_count", 32'(n), 32'd1);

        for (int r = 0; r < 40; r++) begin
            rv  = 4'($urandom_range(0, 15));
            rbp = 1'($urandom_range(0, 1));
            send_vec(rv, int'($urandom_range(0, 2)), rbp, n, cyc);
            check("rand_count", 32'(n), 32'($countones(rv)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitmask_index_encoder.md
Name: bitmask_index_encoder

Overview:
- Sequential counterpart of the 2-to-4 one-hot decoder: converts a multi-hot request vector back into binary indices.
- Accepts an N-bit vector on a valid/ready input handshake.
- Emits the index of every set bit, one per output handshake, highest bit first. The last emitted index is tagged.
- Sits upstream of the decoder, so that decoding each emitted index reproduces exactly one bit of the original vector.

Parameters:
- N, 4, input vector width; power of two, N >= 2.
- W, $clog2(N), index width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers vector `in`.
- in_ready  output  1  block can accept a vector.
- in  input  N  multi-hot request vector.
- out_valid  output  1  `out` holds a valid index.
- out_ready  input  1  downstream accepts `out`.
- out  output  W  binary index of the current highest pending bit.
- out_last  output  1  current index is the final bit of this vector.
- zero_err  output  1  present only with ENC_ZERO_FLAG_EN; see Optional Feature.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst). All state clears immediately on rst assertion, regardless of clock.
- Reset values:
  - state=IDLE, pend=0.
  - in_ready=1, out_valid=0, out=0, out_last=0, zero_err=0.
- States: IDLE, EMIT (2-state FSM, registered).
- IDLE:
  - in_ready=1, out_valid=0.
  - Input accept = in_valid & in_ready at a rising edge.
  - If in != 0: pend <= in, go to EMIT.
  - If in == 0: vector is consumed and dropped; stay in IDLE.
- EMIT:
  - in_ready=0, out_valid=1.
  - out = index of the most-significant set bit of pend (combinational from pend).
  - out_last = 1 iff pend has exactly one bit set.
- Output transfer = out_valid & out_ready at a rising edge:
  - Clears bit `out` in pend.
  - If out_last: go to IDLE, pend becomes 0.
  - Otherwise stay in EMIT; the next index is valid in the following cycle.
- Latency: first index is valid in the cycle after input accept.
- Throughput:
  - A vector with k set bits occupies k cycles of EMIT when out_ready is held high.
  - One IDLE cycle (bubble) separates consecutive vectors.
- Backpressure: while out_ready=0, out, out_last and out_valid hold stable; pend is unchanged.
- out_valid never deasserts without a transfer, except on reset.
- Simultaneous events: in_valid in EMIT is ignored (in_ready=0). No input/output overlap exists.
- Reset mid-EMIT: pending bits are discarded and no further indices are emitted; in_ready=1 once rst deasserts.
- X on `in` while in_valid=0 must not propagate.

Optional Feature:
- Macro: ENC_ZERO_FLAG_EN.
- Defined:
  - Port zero_err exists.
  - zero_err pulses high for exactly one cycle, the cycle after an all-zero vector is accepted in IDLE.
  - Registered; reset value 0.
- Undefined:
  - Port zero_err is absent.
  - All-zero vectors are silently dropped.
- All other behaviour is identical in both builds.

Decomposition:
- Package enc_pkg holds:
  - typedef enum logic {IDLE, EMIT} enc_state_t.
  - Default N constant.
- Sub-module msb_finder: purely combinational; N-bit vector in -> W-bit index of the highest set bit plus a single_bit flag. Instantiated once on pend.

Test Plan:
- Reset and idle: rst pulse mid-cycle, no clock edge required -> in_ready=1, out_valid=0, out=0, out_last=0 immediately.
- Multi-hot vector, no backpressure: in=4'b1011, out_ready=1 -> out sequence 3,1,0 on consecutive cycles; out_last=1 only with 0; then in_ready=1.
- Single bit per value: in=4'b0001, 0010, 0100, 1000 in turn -> out=0,1,2,3, each with out_last=1. Feeding each out into the 2-to-4 decoder reproduces `in`.
- Backpressure: in=4'b1100 with out_ready=0 for 5 cycles -> out=3 held stable with out_valid=1. Release -> out 3 then 2, out_last=1 on 2.
- Zero vector: in=4'b0000 accepted -> no out_valid. With ENC_ZERO_FLAG_EN, a single-cycle zero_err pulse.
- Reset mid-operation: in=4'b1111, assert rst after the first transfer -> out_valid=0 at once. After release, in=4'b0100 -> out=2 with out_last=1; no stale bits emitted.
